// File: rtl/period_meter_pkg.sv
// Shared types and constants for the period meter: FSM state encoding and
// the saturation value of the period counter as a function of its width.
package period_meter_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FIRST = 2'd1,
        MEASURE    = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_N = 32'd8;

    // Largest count an n-bit period counter can hold (2^n - 1), valid for n <= 31.
    function automatic int unsigned cnt_max(input int unsigned n);
        return (32'd1 << n) - 32'd1;
    endfunction

    localparam int unsigned CNT_MAX = cnt_max(DEFAULT_N);

endpackage

// File: rtl/period_meter_rise_detect.sv
// Rising-edge detector for a clk-synchronous tick or level: registers the
// previous sample every cycle and flags a low-to-high transition.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic sig_prev_r;

    // Previous-sample register, updated every cycle regardless of consumer state.
    always_ff @(posedge clk) begin
        if (reset) begin
            sig_prev_r <= 1'b0;
        end else begin
            sig_prev_r <= d;
        end
    end

    assign rise = d & ~sig_prev_r;

endmodule

// File: rtl/period_meter.sv
// Single-shot period meter: after a start request, counts clk cycles between
// two consecutive rising edges of sig_in and reports the count, or saturates.
module period_meter
    import period_meter_pkg::*;
#(
    parameter int unsigned N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         sig_in,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] period,
    output logic         overflow
);

    localparam logic [N-1:0] SAT_VALUE = N'(cnt_max(N));
    localparam logic [N-1:0] CNT_ONE   = N'(1);
    localparam logic [N-1:0] CNT_ZERO  = N'(0);

    state_t       state_r;
    logic [N-1:0] cnt_r;
    logic [N-1:0] period_r;
    logic         busy_r;
    logic         done_r;
    logic         overflow_r;
    logic         rise_s;

    rise_detect u_rise_detect (
        .clk   (clk),
        .reset (reset),
        .d     (sig_in),
        .rise  (rise_s)
    );

    // Measurement FSM; busy/done/period/overflow are all registered here.
    // Saturation is tested before the increment so cnt_r never wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            cnt_r      <= CNT_ZERO;
            period_r   <= CNT_ZERO;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r <= WAIT_FIRST;
                        busy_r  <= 1'b1;
                    end
                end
                WAIT_FIRST: begin
                    if (rise_s) begin
                        cnt_r   <= CNT_ONE;
                        state_r <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (rise_s) begin
                        period_r   <= cnt_r;
                        overflow_r <= 1'b0;
                        done_r     <= 1'b1;
                        busy_r     <= 1'b0;
                        state_r    <= IDLE;
                    end else if (cnt_r == SAT_VALUE) begin
                        period_r   <= SAT_VALUE;
                        overflow_r <= 1'b1;
                        done_r     <= 1'b1;
                        busy_r     <= 1'b0;
                        state_r    <= IDLE;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign period   = period_r;
    assign overflow = overflow_r;

endmodule

// File: doc/period_meter.md
Name: period_meter

Overview:
- Measures the period, in clk cycles, of an external periodic signal such as a mod_counter rollover tick or a square wave.
- Consumes what the counter family produces: a mod counter generates ticks every FINAL_VALUE+1 cycles; this block recovers that interval.
- A single-shot measurement runs per start request.
- Result is held with a done pulse, a busy flag and an overflow flag.

Parameters:
- N, 8, width of the period counter and result; maximum measurable period is 2^N-1 cycles.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high; clears all state
- start  input  1  request one measurement; sampled only in IDLE
- sig_in  input  1  measured signal; synchronous to clk
- busy  output  1  high while a measurement is in progress (WAIT_FIRST or MEASURE)
- done  output  1  one-cycle pulse when period/overflow are updated
- period  output  N  last measured period in clk cycles; held until next done
- overflow  output  1  set with done if the period exceeded 2^N-1; held until next done

Behaviour:
- Interface: one clock `clk`; reset is synchronous and active-high, named `reset`.
- Reset values: state=IDLE, busy=0, done=0, period=0, overflow=0, cnt=0, sig_prev=0.
- Edge detect: sig_prev <= sig_in every cycle, including in IDLE. rise = sig_in & ~sig_prev, combinational.
- States: IDLE, WAIT_FIRST, MEASURE.
- IDLE:
  - start=1 -> WAIT_FIRST.
  - A rise in the same cycle is ignored.
- WAIT_FIRST:
  - On rise: cnt <= 1, go to MEASURE.
  - Otherwise stay; no timeout.
- MEASURE, each cycle:
  - If rise: period <= cnt, overflow <= 0, done <= 1, go to IDLE.
  - Else if cnt == 2^N-1: period <= all ones, overflow <= 1, done <= 1, go to IDLE.
  - Else cnt <= cnt+1.
- Period definition: number of clk edges from the first rise cycle to the second rise cycle. Rises every P cycles give period=P.
- done asserts the cycle after the second rise is visible, i.e. latency 1 cycle. It is high for exactly one cycle, and busy is 0 in that same cycle.
- start while busy is ignored; no queueing.
- Minimum period is 2, since rise requires a low sample in between. A constant-high or constant-low sig_in in MEASURE ends in overflow.
- reset mid-measurement: next cycle is IDLE, all outputs 0, previous result discarded.
- reset has priority over start and rise in the same cycle.
- cnt never wraps; the saturation check precedes increment.
- period and overflow change only on done or reset.

Decomposition:
- Package period_meter_pkg: state enum (IDLE, WAIT_FIRST, MEASURE) and localparam CNT_MAX = 2^N-1 as a function of N.
- Sub-module rise_detect (clk, reset, d, rise): the sig_prev register plus AND gate. Reused wherever tick inputs are consumed.

Test Plan:
- Reset then idle: hold reset 2 cycles, release with start=0 and sig_in toggling -> busy=0, done never pulses, period=0, overflow=0.
- Against mod_counter ticks: sig_in driven by a one-cycle tick every 6 cycles (FINAL_VALUE=5), pulse start -> done exactly once, period=6, overflow=0, busy falls in the done cycle.
- Square wave 3 high / 4 low (P=7), N=8, two back-to-back starts -> both results period=7, done once each, busy low between runs.
- Overflow: N=4, start, one rise, then sig_in held low -> done after 15 MEASURE cycles, period=4'hF, overflow=1. A subsequent run at P=5 clears overflow and reports period=5.
- start ignored while busy: pulse start again during MEASURE with P=9 -> single done, period=9, no second measurement started.
- Reset mid-measurement: assert reset 3 cycles after the first rise -> next cycle busy=0, period=0, no done. A fresh start then measures P=5 correctly.
